// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory stage: data-bus access with lane steering, load extension and registered writeback
// Optional feature macro: LSU_MISALIGNED_TRAP_EN (trap misaligned half/word accesses instead of aligning them)
module load_store_unit #(
   parameter int unsigned BUS_TIMEOUT = 0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_alu_result,
   input  logic [31:0] in_store_data,
   input  logic        in_is_load,
   input  logic        in_is_store,
   input  logic [2:0]  in_func3,
   input  logic [4:0]  in_rd,
   input  logic        in_wb_en,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_rd,
   output logic        out_wb_en,
   output logic [31:0] out_data,
   output logic        out_trap,
   output logic [3:0]  out_trap_cause,
   output logic [31:0] out_trap_tval
);
   typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;
   state_t r_state, w_state_nxt;

   logic [31:0] r_addr, r_cnt;
   logic [2:0]  r_func3;
   logic [1:0]  r_lane;
   logic [4:0]  r_rd;
   logic        r_wb_en, r_is_load;
   logic        w_accept, w_mem_op, w_trap_mis, w_timeout;
   logic [1:0]  w_lane;
   logic [3:0]  w_wstrb;
   logic [31:0] w_wdata, w_load_data;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign in_ready  = (r_state == IDLE) && (!out_valid || out_ready);
   assign w_accept  = in_valid && in_ready;
   assign w_mem_op  = in_is_load || in_is_store;
   assign w_timeout = (BUS_TIMEOUT != 0) && (r_cnt == BUS_TIMEOUT - 1);

`ifdef LSU_MISALIGNED_TRAP_EN
   always_comb begin
      w_trap_mis = 1'b0;
      if (w_mem_op) begin
         if (in_func3[1:0] == 2'b01)      w_trap_mis = in_alu_result[0];
         else if (in_func3[1:0] == 2'b10) w_trap_mis = |in_alu_result[1:0];
      end
   end
`else
   assign w_trap_mis = 1'b0;
`endif

   // Half/word lanes are forced to natural alignment; only reachable misaligned when trapping is off.
   always_comb begin
      w_lane = in_alu_result[1:0];
      if (in_func3[1:0] == 2'b01)      w_lane[0] = 1'b0;
      else if (in_func3[1:0] == 2'b10) w_lane    = 2'b00;
   end

   always_comb begin
      w_wstrb = 4'b0000;
      w_wdata = 32'd0;
      if (in_is_store) begin
         case (in_func3[1:0])
            2'b00:   begin w_wstrb = 4'b0001 << w_lane; w_wdata = {4{in_store_data[7:0]}};  end
            2'b01:   begin w_wstrb = 4'b0011 << w_lane; w_wdata = {2{in_store_data[15:0]}}; end
            default: begin w_wstrb = 4'b1111;           w_wdata = in_store_data;            end
         endcase
      end
   end

   assign w_byte = mem_rdata[{r_lane, 3'b000} +: 8];
   assign w_half = mem_rdata[{r_lane[1], 4'b0000} +: 16];

   always_comb begin
      case (r_func3)
         3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
         3'b100:  w_load_data = {24'd0, w_byte};
         3'b101:  w_load_data = {16'd0, w_half};
         default: w_load_data = mem_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_accept && w_mem_op && !w_trap_mis) w_state_nxt = BUS;
         BUS:     if (mem_ready || w_timeout) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= 32'd0;
         mem_wdata      <= 32'd0;
         mem_wstrb      <= 4'd0;
         out_valid      <= 1'b0;
         out_rd         <= 5'd0;
         out_wb_en      <= 1'b0;
         out_data       <= 32'd0;
         out_trap       <= 1'b0;
         out_trap_cause <= 4'd0;
         out_trap_tval  <= 32'd0;
         r_addr         <= 32'd0;
         r_cnt          <= 32'd0;
         r_func3        <= 3'd0;
         r_lane         <= 2'd0;
         r_rd           <= 5'd0;
         r_wb_en        <= 1'b0;
         r_is_load      <= 1'b0;
      end else if (r_state == IDLE) begin
         if (out_valid && out_ready) out_valid <= 1'b0;
         if (w_accept) begin
            if (!w_mem_op || w_trap_mis) begin
               out_valid      <= 1'b1;
               out_rd         <= in_rd;
               out_wb_en      <= w_mem_op ? 1'b0 : in_wb_en;
               out_data       <= w_mem_op ? 32'd0 : in_alu_result;
               out_trap       <= w_trap_mis;
               out_trap_cause <= w_trap_mis ? (in_is_load ? 4'd4 : 4'd6) : 4'd0;
               out_trap_tval  <= w_trap_mis ? in_alu_result : 32'd0;
            end else begin
               mem_req   <= 1'b1;
               mem_we    <= in_is_store;
               mem_addr  <= {in_alu_result[31:2], 2'b00};
               mem_wdata <= w_wdata;
               mem_wstrb <= w_wstrb;
               r_addr    <= in_alu_result;
               r_cnt     <= 32'd0;
               r_func3   <= in_func3;
               r_lane    <= w_lane;
               r_rd      <= in_rd;
               r_wb_en   <= in_wb_en;
               r_is_load <= in_is_load;
            end
         end
      end else if (mem_ready || w_timeout) begin
         // mem_ready takes priority over a simultaneous timeout expiry.
         mem_req        <= 1'b0;
         out_valid      <= 1'b1;
         out_rd         <= r_rd;
         out_trap       <= !mem_ready;
         out_trap_cause <= mem_ready ? 4'd0 : (r_is_load ? 4'd5 : 4'd7);
         out_trap_tval  <= mem_ready ? 32'd0 : r_addr;
         out_wb_en      <= mem_ready && r_is_load && r_wb_en;
         out_data       <= (mem_ready && r_is_load) ? w_load_data : 32'd0;
      end else begin
         r_cnt <= r_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit (BUS_TIMEOUT = 4)
// Honours LSU_MISALIGNED_TRAP_EN when selecting misaligned-access expectations.
module tb_load_store_unit;
   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [31:0] in_alu_result, in_store_data;
   logic        in_is_load, in_is_store;
   logic [2:0]  in_func3;
   logic [4:0]  in_rd;
   logic        in_wb_en;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        out_valid, out_ready;
   logic [4:0]  out_rd;
   logic        out_wb_en;
   logic [31:0] out_data;
   logic        out_trap;
   logic [3:0]  out_trap_cause;
   logic [31:0] out_trap_tval;

   typedef struct packed {
      logic [31:0] data;
      logic [4:0]  rd;
      logic        wb_en;
      logic        trap;
      logic [3:0]  cause;
      logic [31:0] tval;
   } exp_t;

   exp_t sb[$];
   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   load_store_unit #(.BUS_TIMEOUT(4)) dut (
      .clk(clk), .reset_n(reset_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_alu_result(in_alu_result), .in_store_data(in_store_data),
      .in_is_load(in_is_load), .in_is_store(in_is_store),
      .in_func3(in_func3), .in_rd(in_rd), .in_wb_en(in_wb_en),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_rd(out_rd), .out_wb_en(out_wb_en), .out_data(out_data),
      .out_trap(out_trap), .out_trap_cause(out_trap_cause), .out_trap_tval(out_trap_tval)
   );

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output: got out_data %h, required no writeback", out_data);
         end else begin
            e = sb.pop_front();
            if (out_data !== e.data) begin
               errors++;
               $display("FAIL wb_data: got %h required %h", out_data, e.data);
            end
            checks++;
            if ({out_rd, out_wb_en, out_trap, out_trap_cause, out_trap_tval} !==
                {e.rd, e.wb_en, e.trap, e.cause, e.tval}) begin
               errors++;
               $display("FAIL wb_meta: got rd %0d wb_en %b trap %b cause %0d tval %h required rd %0d wb_en %b trap %b cause %0d tval %h",
                        out_rd, out_wb_en, out_trap, out_trap_cause, out_trap_tval,
                        e.rd, e.wb_en, e.trap, e.cause, e.tval);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic drive_op(input logic ld, input logic st, input logic [2:0] f3,
                           input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] rd, input logic wb);
      in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_func3 = f3;
      in_alu_result = alu; in_store_data = sd; in_rd = rd; in_wb_en = wb;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({mem_req, mem_we, mem_wstrb, out_valid, out_wb_en, out_trap} !== 9'd0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b required 0", {mem_req, mem_we, mem_wstrb, out_valid, out_wb_en, out_trap});
      end
      checks++;
      if ({mem_addr, mem_wdata, out_data, out_rd, out_trap_cause, out_trap_tval} !== 137'd0) begin
         errors++;
         $display("FAIL reset_data: got addr %h wdata %h data %h required 0", mem_addr, mem_wdata, out_data);
      end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
      cyc();
      reset_n = 1'b1;
   endtask

   task automatic test_nonmem();
      cyc();
      drive_op(1'b0, 1'b0, 3'b000, 32'h1234_5678, 32'd0, 5'd3, 1'b1);
      sb.push_back('{data: 32'h1234_5678, rd: 5'd3, wb_en: 1'b1, trap: 1'b0, cause: 4'd0, tval: 32'd0});
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL nonmem_accept: got %b required 1", in_ready); end
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1234_5678 || out_rd !== 5'd3) begin
         errors++;
         $display("FAIL nonmem_latency: got valid %b data %h rd %0d required 1 12345678 3", out_valid, out_data, out_rd);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         cyc();
         drive_op(1'b0, 1'b0, 3'b000, 32'hA000_0000 + i, 32'd0, 5'(10 + i), i[0]);
         sb.push_back('{data: 32'hA000_0000 + i, rd: 5'(10 + i), wb_en: i[0], trap: 1'b0, cause: 4'd0, tval: 32'd0});
         @(negedge clk);
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: op %0d got %b required 1", i, in_ready); end
         if (i > 0) begin
            checks++;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out_valid: op %0d got %b required 1", i, out_valid); end
         end
      end
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      cyc();
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL b2b_drain: got valid %b pending %0d required 0 0", out_valid, sb.size());
      end
   endtask

   task automatic test_idle_ready();
      cyc();
      mem_ready = 1'b1;
      mem_rdata = 32'h5555_AAAA;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready_ignored: got req %b valid %b required 0 0", mem_req, out_valid);
         end
         if (k == 0) cyc();
      end
      cyc();
      mem_ready = 1'b0;
   endtask

   task automatic do_mem(input string name, input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd,
                         input logic [31:0] exp_maddr, input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                         input logic [31:0] rdata, input logic [31:0] exp_out, input int wait_n, input int hold_n);
      cyc();
      drive_op(ld, st, f3, addr, sdata, rd, 1'b1);
      sb.push_back('{data: st ? 32'd0 : exp_out, rd: rd, wb_en: !st, trap: 1'b0, cause: 4'd0, tval: 32'd0});
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_accept: got in_ready %b required 1", name, in_ready); end
      cyc();
      in_valid = 1'b0;
      mem_ready = (wait_n == 0);
      mem_rdata = rdata;
      if (wait_n == 0 && hold_n > 0) out_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1 || mem_we !== st || mem_addr !== exp_maddr || mem_wstrb !== exp_strb || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_request: got req %b we %b addr %h strb %b in_ready %b required 1 %b %h %b 0",
                  name, mem_req, mem_we, mem_addr, mem_wstrb, in_ready, st, exp_maddr, exp_strb);
      end
      if (st) begin
         checks++;
         if (mem_wdata !== exp_wdata) begin errors++; $display("FAIL %s_wdata: got %h required %h", name, mem_wdata, exp_wdata); end
      end
      for (int w = 1; w <= wait_n; w++) begin
         cyc();
         mem_ready = (w == wait_n);
         if (w == wait_n && hold_n > 0) out_ready = 1'b0;
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1 || mem_addr !== exp_maddr || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait: cycle %0d got req %b addr %h in_ready %b valid %b required 1 %h 0 0",
                     name, w, mem_req, mem_addr, in_ready, out_valid, exp_maddr);
         end
      end
      cyc();
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL %s_complete: got req %b valid %b required 0 1", name, mem_req, out_valid);
      end
      for (int h = 1; h < hold_n; h++) begin
         cyc();
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== exp_out || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_hold: got valid %b data %h in_ready %b required 1 %h 0", name, out_valid, out_data, in_ready, exp_out);
         end
      end
      if (hold_n > 0) begin
         cyc();
         out_ready = 1'b1;
      end
   endtask

   task automatic test_stores();
      do_mem("sb", 1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 5'd4,
             32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 32'd0, 32'd0, 0, 0);
      do_mem("sh", 1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'hAABB_CCDD, 5'd4,
             32'h0000_1000, 4'b1100, 32'hCCDD_CCDD, 32'd0, 32'd0, 1, 0);
      do_mem("sw", 1'b0, 1'b1, 3'b010, 32'h0000_1004, 32'h1234_5678, 5'd4,
             32'h0000_1004, 4'b1111, 32'h1234_5678, 32'd0, 32'd0, 0, 0);
   endtask

   task automatic test_loads();
      do_mem("lb", 1'b1, 1'b0, 3'b000, 32'h0000_2002, 32'd0, 5'd5,
             32'h0000_2000, 4'b0000, 32'd0, 32'h0080_0000, 32'hFFFF_FF80, 0, 0);
      do_mem("lbu", 1'b1, 1'b0, 3'b100, 32'h0000_2002, 32'd0, 5'd6,
             32'h0000_2000, 4'b0000, 32'd0, 32'h0080_0000, 32'h0000_0080, 0, 0);
      do_mem("lh", 1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'd0, 5'd7,
             32'h0000_2000, 4'b0000, 32'd0, 32'h8001_0000, 32'hFFFF_8001, 0, 0);
      do_mem("lhu", 1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'd0, 5'd8,
             32'h0000_2000, 4'b0000, 32'd0, 32'h1234_F00D, 32'h0000_F00D, 0, 0);
      do_mem("lb_pos", 1'b1, 1'b0, 3'b000, 32'h0000_2001, 32'd0, 5'd9,
             32'h0000_2000, 4'b0000, 32'd0, 32'h0000_7F00, 32'h0000_007F, 0, 0);
      do_mem("lw_wait", 1'b1, 1'b0, 3'b010, 32'h0000_2004, 32'd0, 5'd10,
             32'h0000_2004, 4'b0000, 32'd0, 32'hA5A5_5A5A, 32'hA5A5_5A5A, 3, 2);
   endtask

   task automatic test_timeout_reset();
      cyc();
      drive_op(1'b0, 1'b1, 3'b010, 32'h0000_4008, 32'h1122_3344, 5'd7, 1'b1);
      sb.push_back('{data: 32'd0, rd: 5'd7, wb_en: 1'b0, trap: 1'b1, cause: 4'd7, tval: 32'h0000_4008});
      @(negedge clk);
      cyc();
      in_valid = 1'b0;
      mem_ready = 1'b0;
      for (int w = 1; w <= 4; w++) begin
         if (w > 1) cyc();
         @(negedge clk);
         checks++;
         if (mem_req !== 1'b1) begin errors++; $display("FAIL timeout_req_held: cycle %0d got %b required 1", w, mem_req); end
      end
      cyc();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_trap !== 1'b1) begin
         errors++;
         $display("FAIL timeout_expire: got req %b valid %b trap %b required 0 1 1", mem_req, out_valid, out_trap);
      end
      cyc();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'd0, 5'd9, 1'b1);
      @(negedge clk);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_bus_entry: got req %b required 1", mem_req); end
      cyc();
      reset_n = 1'b0;
      #1;
      checks++;
      if (mem_req !== 1'b0 || mem_addr !== 32'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL async_reset: got req %b addr %h valid %b in_ready %b required 0 0 0 1", mem_req, mem_addr, out_valid, in_ready);
      end
      cyc();
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      cyc();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_abandon: got req %b valid %b required 0 0", mem_req, out_valid);
      end
   endtask

   task automatic test_misaligned();
`ifdef LSU_MISALIGNED_TRAP_EN
      cyc();
      drive_op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'd0, 5'd11, 1'b1);
      sb.push_back('{data: 32'd0, rd: 5'd11, wb_en: 1'b0, trap: 1'b1, cause: 4'd4, tval: 32'h0000_3002});
      @(negedge clk);
      cyc();
      drive_op(1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h0000_BEEF, 5'd12, 1'b1);
      sb.push_back('{data: 32'd0, rd: 5'd12, wb_en: 1'b0, trap: 1'b1, cause: 4'd6, tval: 32'h0000_3001});
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_trap !== 1'b1) begin
         errors++;
         $display("FAIL mis_lw_trap: got req %b valid %b trap %b required 0 1 1", mem_req, out_valid, out_trap);
      end
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || out_valid !== 1'b1 || out_trap_cause !== 4'd6) begin
         errors++;
         $display("FAIL mis_sh_trap: got req %b valid %b cause %0d required 0 1 6", mem_req, out_valid, out_trap_cause);
      end
`else
      do_mem("mis_lw", 1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'd0, 5'd11,
             32'h0000_3000, 4'b0000, 32'd0, 32'hCAFE_BABE, 32'hCAFE_BABE, 0, 0);
      do_mem("mis_lh", 1'b1, 1'b0, 3'b001, 32'h0000_3003, 32'd0, 5'd12,
             32'h0000_3000, 4'b0000, 32'd0, 32'h8765_4321, 32'hFFFF_8765, 0, 0);
      do_mem("mis_sh", 1'b0, 1'b1, 3'b001, 32'h0000_3001, 32'h0000_BEEF, 5'd13,
             32'h0000_3000, 4'b0011, 32'hBEEF_BEEF, 32'd0, 32'd0, 0, 0);
`endif
      cyc();
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n = 1'b0;
      in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_func3 = 3'd0;
      in_alu_result = 32'd0; in_store_data = 32'd0; in_rd = 5'd0; in_wb_en = 1'b0;
      mem_ready = 1'b0; mem_rdata = 32'd0; out_ready = 1'b1;
      test_reset();
      test_nonmem();
      test_back_to_back();
      test_idle_ready();
      test_stores();
      test_loads();
      test_timeout_reset();
      test_misaligned();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_empty: got %0d pending required 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
